// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } dcache_state_e;

  localparam int WORD_BITS = 32;

  function automatic int offset_width(input int block_size);
    return $clog2(block_size / 8);
  endfunction

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int block_size, input int num_sets);
    return 32 - offset_width(block_size) - index_width(num_sets);
  endfunction

  function automatic int rr_width(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Victim way selection for one set: lowest invalid way, otherwise the round-robin pointer.
module dcache_victim_sel #(
  parameter int NUM_WAYS = 4,
  parameter int RR_W     = 2
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [RR_W-1:0]     rr_i,
  output logic [NUM_WAYS-1:0] victim_o,
  output logic [RR_W-1:0]     rr_next_o
);

  always_comb begin
    victim_o  = '0;
    rr_next_o = rr_i;
    if (&valid_i) begin
      victim_o  = NUM_WAYS'(1) << rr_i;
      rr_next_o = (int'(rr_i) == NUM_WAYS - 1) ? '0 : rr_i + 1'b1;
    end else begin
      // Descending scan so the lowest invalid way is the last one written.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (!valid_i[w]) victim_o = NUM_WAYS'(1) << w;
      end
    end
  end

endmodule

// File: rtl/assoc_data_cache.sv
// N-way set-associative write-through L1 data cache with an internal refill FSM.
// Define DCACHE_STATS_EN to add saturating load hit/miss counters (hit_cnt_o, miss_cnt_o).
module assoc_data_cache
  import dcache_pkg::*;
#(
  parameter int BLOCK_SIZE = 128,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_en,
  input  logic [31:0]           r_addr_i,
  output logic [31:0]           r_data_o,
  output logic                  r_valid_o,
  output logic                  r_hit_o,
  input  logic                  w_en,
  input  logic [31:0]           w_addr_i,
  input  logic [31:0]           w_data_i,
  input  logic [3:0]            w_strb_i,
  output logic                  w_hit_o,
  input  logic                  flush_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [31:0]           mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BLOCK_SIZE-1:0] mem_resp_data_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
`endif
  output logic                  busy_o
);

  localparam int OFF_W = offset_width(BLOCK_SIZE);
  localparam int IDX_W = index_width(NUM_SETS);
  localparam int TAG_W = tag_width(BLOCK_SIZE, NUM_SETS);
  localparam int WORDS = BLOCK_SIZE / WORD_BITS;
  localparam int RR_W  = rr_width(NUM_WAYS);

  dcache_state_e state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic          r_valid_q, r_valid_d;
  logic          r_hit_q, r_hit_d;
  logic [31:0]   r_data_q, r_data_d;
  logic          w_hit_q, w_hit_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]                 valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0]      tag_q, tag_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][BLOCK_SIZE-1:0] data_q, data_d;
  logic [NUM_SETS-1:0][RR_W-1:0]                     rr_q, rr_d;

  logic [IDX_W-1:0] rd_idx, wr_idx, miss_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag, miss_tag;
  int               rd_word, wr_word, miss_word;

  assign rd_idx    = r_addr_i[OFF_W +: IDX_W];
  assign rd_tag    = r_addr_i[31 -: TAG_W];
  assign rd_word   = int'((r_addr_i >> 2) & 32'(WORDS - 1));
  assign wr_idx    = w_addr_i[OFF_W +: IDX_W];
  assign wr_tag    = w_addr_i[31 -: TAG_W];
  assign wr_word   = int'((w_addr_i >> 2) & 32'(WORDS - 1));
  assign miss_idx  = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag  = miss_addr_q[31 -: TAG_W];
  assign miss_word = int'((miss_addr_q >> 2) & 32'(WORDS - 1));

  logic                rd_hit, wr_hit;
  logic [31:0]         rd_data;
  logic [NUM_WAYS-1:0] wr_way;

  // At most one way of a set can match, so OR-style accumulation is safe.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    wr_hit  = 1'b0;
    wr_way  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
        rd_hit = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
          if (k == rd_word) rd_data = data_q[rd_idx][w][k*WORD_BITS +: WORD_BITS];
        end
      end
      if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
        wr_hit    = 1'b1;
        wr_way[w] = 1'b1;
      end
    end
  end

  logic [NUM_WAYS-1:0] fill_valid, victim;
  logic [RR_W-1:0]     fill_rr, rr_next;

  // A flush in the fill cycle is applied first, so the fill sees an empty set.
  assign fill_valid = flush_i ? '0 : valid_q[miss_idx];
  assign fill_rr    = flush_i ? '0 : rr_q[miss_idx];

  dcache_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .RR_W     (RR_W)
  ) u_victim_sel (
    .valid_i   (fill_valid),
    .rr_i      (fill_rr),
    .victim_o  (victim),
    .rr_next_o (rr_next)
  );

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    r_valid_d   = 1'b0;
    r_hit_d     = 1'b0;
    r_data_d    = r_data_q;
    w_hit_d     = 1'b0;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    rr_d        = rr_q;

    if (flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end

    case (state_q)
      IDLE: begin
        if (r_en) begin
          if (rd_hit) begin
            r_valid_d = 1'b1;
            r_hit_d   = 1'b1;
            r_data_d  = rd_data;
          end else begin
            miss_addr_d = r_addr_i;
            state_d     = REQ;
          end
        end
        if (w_en && wr_hit) begin
          w_hit_d = 1'b1;
          for (int w = 0; w < NUM_WAYS; w++) begin
            for (int k = 0; k < WORDS; k++) begin
              for (int b = 0; b < 4; b++) begin
                if (wr_way[w] && k == wr_word && w_strb_i[b])
                  data_d[wr_idx][w][k*WORD_BITS + b*8 +: 8] = w_data_i[b*8 +: 8];
              end
            end
          end
        end
      end
      REQ: begin
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid_i) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (victim[w]) begin
              data_d[miss_idx][w]  = mem_resp_data_i;
              tag_d[miss_idx][w]   = miss_tag;
              valid_d[miss_idx][w] = 1'b1;
            end
          end
          rr_d[miss_idx] = rr_next;
          for (int k = 0; k < WORDS; k++) begin
            if (k == miss_word) r_data_d = mem_resp_data_i[k*WORD_BITS +: WORD_BITS];
          end
          r_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      r_valid_q   <= 1'b0;
      r_hit_q     <= 1'b0;
      r_data_q    <= '0;
      w_hit_q     <= 1'b0;
      valid_q     <= '0;
      tag_q       <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      r_valid_q   <= r_valid_d;
      r_hit_q     <= r_hit_d;
      r_data_q    <= r_data_d;
      w_hit_q     <= w_hit_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      rr_q        <= rr_d;
    end
  end

  // The data array is qualified by valid bits and deliberately has no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign r_valid_o       = r_valid_q;
  assign r_hit_o         = r_hit_q;
  assign r_data_o        = r_data_q;
  assign w_hit_o         = w_hit_q;
  assign busy_o          = (state_q != IDLE);
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = {miss_addr_q[31:OFF_W], OFF_W'(0)};

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && r_en) begin
      if (rd_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_data_cache.sv
// Self-checking bench for assoc_data_cache: directed plan steps plus randomized traffic
// against a line-level cache model and a word-addressed backing memory.
module tb_assoc_data_cache;

  localparam int NSETS = 16;
  localparam int NWAYS = 4;

  logic         clk, rst;
  logic         r_en, w_en, flush_i;
  logic [31:0]  r_addr_i, w_addr_i, w_data_i;
  logic [3:0]   w_strb_i;
  logic [31:0]  r_data_o, mem_req_addr_o;
  logic         r_valid_o, r_hit_o, w_hit_o, busy_o, mem_req_valid_o;
  logic         mem_req_ready_i, mem_resp_valid_i;
  logic [127:0] mem_resp_data_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  assoc_data_cache dut (
    .clk              (clk),
    .rst              (rst),
    .r_en             (r_en),
    .r_addr_i         (r_addr_i),
    .r_data_o         (r_data_o),
    .r_valid_o        (r_valid_o),
    .r_hit_o          (r_hit_o),
    .w_en             (w_en),
    .w_addr_i         (w_addr_i),
    .w_data_i         (w_data_i),
    .w_strb_i         (w_strb_i),
    .w_hit_o          (w_hit_o),
    .flush_i          (flush_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o),
`endif
    .busy_o           (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;
  int n_hits = 0;
  int n_misses = 0;

  bit          m_valid [NSETS][NWAYS];
  logic [23:0] m_tag   [NSETS][NWAYS];
  int          m_rr    [NSETS];
  logic [31:0] mem_q   [logic [31:0]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] aw = a & ~32'h3;
    if (mem_q.exists(aw)) return mem_q[aw];
    return (aw * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w = mem_word(a);
    for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mem_q[a & ~32'h3] = w;
  endfunction

  function automatic logic [127:0] build_line(input logic [31:0] a);
    logic [127:0] line;
    for (int k = 0; k < 4; k++) line[k*32 +: 32] = mem_word((a & ~32'hF) + 32'(4 * k));
    return line;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'((a >> 4) % NSETS);
    logic [23:0] t = a[31:8];
    for (int w = 0; w < NWAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Victim rule: first empty way, otherwise the set's round-robin pointer.
  function automatic void model_fill(input logic [31:0] a);
    int s = int'((a >> 4) % NSETS);
    int v = -1;
    for (int w = 0; w < NWAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NWAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = a[31:8];
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] t = 32'h10 + $urandom_range(0, 5);
    logic [31:0] s = $urandom_range(0, 2);
    logic [31:0] k = $urandom_range(0, 3);
    return (t << 8) | (s << 4) | (k << 2) | 32'($urandom_range(0, 3));
  endfunction

  // One request cycle; all tasks enter and leave on a falling edge.
  task automatic applyStimulus(input logic rd, input logic [31:0] ra, input logic wr,
                               input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    r_en = rd; r_addr_i = ra;
    w_en = wr; w_addr_i = wa; w_data_i = wd; w_strb_i = ws;
    @(negedge clk);
    r_en = 1'b0; w_en = 1'b0;
    r_addr_i = $urandom; w_addr_i = $urandom;
  endtask

  task automatic do_load(input logic [31:0] a, input int rdy_dly, input int rsp_dly,
                         input string tag, output logic obs_hit);
    logic        exp_hit = model_hit(a);
    logic [31:0] exp_data = mem_word(a);
    applyStimulus(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    obs_hit = r_valid_o;
    if (exp_hit) begin
      n_hits++;
      checkOutput({tag, "_valid"}, r_valid_o, 1);
      checkOutput({tag, "_hit"}, r_hit_o, 1);
      checkOutput({tag, "_data"}, r_data_o, exp_data);
      checkOutput({tag, "_busy"}, busy_o, 0);
    end else begin
      n_misses++;
      checkOutput({tag, "_c1_valid"}, r_valid_o, 0);
      checkOutput({tag, "_c1_busy"}, busy_o, 1);
      checkOutput({tag, "_req_valid"}, mem_req_valid_o, 1);
      checkOutput({tag, "_req_addr"}, mem_req_addr_o, a & ~32'hF);
      for (int i = 0; i < rdy_dly; i++) begin
        applyStimulus(1'b1, (i % 2 == 0) ? 32'h500 : rand_addr(), 1'b1, 32'h500, $urandom, 4'hF);
        checkOutput({tag, "_stall_req"}, mem_req_valid_o, 1);
        checkOutput({tag, "_stall_addr"}, mem_req_addr_o, a & ~32'hF);
        checkOutput({tag, "_stall_busy"}, busy_o, 1);
        checkOutput({tag, "_stall_rvalid"}, r_valid_o, 0);
        checkOutput({tag, "_stall_whit"}, w_hit_o, 0);
      end
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      checkOutput({tag, "_wait_req"}, mem_req_valid_o, 0);
      checkOutput({tag, "_wait_busy"}, busy_o, 1);
      for (int i = 0; i < rsp_dly; i++) begin
        flush_i = ($urandom_range(0, 7) == 0);
        if (flush_i) model_flush();
        @(negedge clk);
        flush_i = 1'b0;
        checkOutput({tag, "_wait_rvalid"}, r_valid_o, 0);
      end
      flush_i = ($urandom_range(0, 7) == 0);
      if (flush_i) model_flush();
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = build_line(a);
      @(negedge clk);
      flush_i = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
      checkOutput({tag, "_fill_valid"}, r_valid_o, 1);
      checkOutput({tag, "_fill_hit"}, r_hit_o, 0);
      checkOutput({tag, "_fill_data"}, r_data_o, exp_data);
      checkOutput({tag, "_fill_busy"}, busy_o, 0);
      model_fill(a);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb, input string tag);
    logic exp_hit = model_hit(a);
    applyStimulus(1'b0, 32'h0, 1'b1, a, d, strb);
    checkOutput({tag, "_whit"}, w_hit_o, 32'(exp_hit));
    mem_write(a, d, strb);
  endtask

  task automatic do_load_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] old = mem_word(a);
    applyStimulus(1'b1, a, 1'b1, a, d, strb);
    n_hits++;
    checkOutput("ls_valid", r_valid_o, 1);
    checkOutput("ls_pre_store_data", r_data_o, old);
    checkOutput("ls_whit", w_hit_o, 1);
    mem_write(a, d, strb);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    model_flush();
    checkOutput("flush_rvalid", r_valid_o, 0);
  endtask

  task automatic model_reset();
    model_flush();
    n_hits = 0;
    n_misses = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic h;
    int   op;
    logic [31:0] a;

    rst = 1'b0; r_en = 1'b0; w_en = 1'b0; flush_i = 1'b0;
    r_addr_i = '0; w_addr_i = '0; w_data_i = '0; w_strb_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("rst_rvalid", r_valid_o, 0);
    checkOutput("rst_rhit", r_hit_o, 0);
    checkOutput("rst_rdata", r_data_o, 0);
    checkOutput("rst_whit", w_hit_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_req_valid", mem_req_valid_o, 0);
    checkOutput("rst_req_addr", mem_req_addr_o, 0);
    rst = 1'b1;
    @(negedge clk);

    mem_q[32'h104] = 32'hDEADBEEF;
    do_load(32'h100, 0, 0, "plan_first", h);
    checkOutput("plan_first_is_miss", 32'(h), 0);
    do_load(32'h104, 0, 0, "plan_second", h);
    checkOutput("plan_second_is_hit", 32'(h), 1);
    checkOutput("plan_deadbeef", r_data_o, 32'hDEADBEEF);

    do_load(32'h200, 1, 0, "set0_t2", h);
    do_load(32'h300, 0, 1, "set0_t3", h);
    do_load(32'h400, 2, 2, "set0_t4", h);
    do_load(32'h500, 0, 0, "set0_t5", h);
    do_load(32'h100, 0, 0, "reread_t1", h);
    checkOutput("reread_t1_misses", 32'(h), 0);
    do_load(32'h308, 0, 0, "t3_kept", h);
    checkOutput("t3_kept_hit", 32'(h), 1);
    do_load(32'h200, 0, 0, "t2_evicted", h);
    checkOutput("t2_evicted_miss", 32'(h), 0);

    do_load(32'h30000040, 5, 2, "stall", h);
    do_load(32'h500, 0, 0, "dropped_store_check", h);
    checkOutput("dropped_store_hit", 32'(h), 1);

    mem_q[32'h1008] = 32'h11223344;
    do_load(32'h1008, 0, 0, "merge_fill", h);
    do_store(32'h1008, 32'hAABBCCDD, 4'b0101, "merge_store");
    do_load(32'h1008, 0, 0, "merge_read", h);
    checkOutput("merge_read_hit", 32'(h), 1);
    checkOutput("merge_value", r_data_o, 32'h11BB33DD);
    do_store(32'h7770, 32'h01020304, 4'hF, "store_miss");
    do_load(32'h7770, 0, 0, "store_miss_read", h);
    do_load_store(32'h1008, 32'h55667788, 4'b1010);
    do_load(32'h100A, 0, 0, "ls_post", h);

    do_flush();
    do_load(32'h500, 0, 0, "flush_t5", h);
    checkOutput("flush_t5_miss", 32'(h), 0);
    do_load(32'h1008, 0, 0, "flush_merge", h);
    checkOutput("flush_merge_miss", 32'(h), 0);
`ifdef DCACHE_STATS_EN
    checkOutput("stats_hits", hit_cnt_o, 32'(n_hits));
    checkOutput("stats_misses", miss_cnt_o, 32'(n_misses));
`endif

    // Reset while the request is pending must drop it immediately.
    applyStimulus(1'b1, 32'h9990, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rstreq_req_before", mem_req_valid_o, 1);
    #2 rst = 1'b0;
    #1 checkOutput("rstreq_async_drop", mem_req_valid_o, 0);
    checkOutput("rstreq_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);

    applyStimulus(1'b1, 32'h8880, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    checkOutput("rstwait_busy_before", busy_o, 1);
    #2 rst = 1'b0;
    #1 checkOutput("rstwait_async_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = build_line(32'h8880);
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    checkOutput("rstwait_no_rvalid", r_valid_o, 0);
    do_load(32'h8880, 0, 0, "rstwait_reload", h);
    checkOutput("rstwait_not_installed", 32'(h), 0);

    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 11);
      a  = rand_addr();
      if (op <= 5) begin
        do_load(a, $urandom_range(0, 3), $urandom_range(0, 2), "rnd_load", h);
      end else if (op <= 8) begin
        do_store(a, $urandom, 4'($urandom_range(0, 15)), "rnd_store");
      end else if (op == 9) begin
        if (model_hit(a)) do_load_store(a, $urandom, 4'($urandom_range(0, 15)));
        else do_load(a, 0, 0, "rnd_load2", h);
      end else if (op == 10) begin
        if ($urandom_range(0, 3) == 0) do_flush();
      end else begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        mem_resp_valid_i = 1'b0;
        checkOutput("stray_resp_rvalid", r_valid_o, 0);
        checkOutput("stray_resp_busy", busy_o, 0);
      end
    end

`ifdef DCACHE_STATS_EN
    checkOutput("final_hits", hit_cnt_o, 32'(n_hits));
    checkOutput("final_misses", miss_cnt_o, 32'(n_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
